// File: rtl/pipe_register_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_register_if : control/data bundle for pipe_register             |
// | Build option: PIPE_REGISTER_PARITY_EN adds the parity_err signal.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pipe_register_if #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
);
    logic                         stall;
    logic                         flush;
    logic                         in_valid;
    logic [WIDTH-1:0]             D;
    logic [WIDTH-1:0]             Q;
    logic                         out_valid;
    logic [$clog2(STAGES+1)-1:0]  occupancy;
`ifdef PIPE_REGISTER_PARITY_EN
    logic                         parity_err;

    modport master (
        output stall, flush, in_valid, D,
        input  Q, out_valid, occupancy, parity_err
    );
    modport slave (
        input  stall, flush, in_valid, D,
        output Q, out_valid, occupancy, parity_err
    );
`else
    modport master (
        output stall, flush, in_valid, D,
        input  Q, out_valid, occupancy
    );
    modport slave (
        input  stall, flush, in_valid, D,
        output Q, out_valid, occupancy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pipe_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_register : STAGES-deep register pipe with valid, stall, flush.  |
// | Build option: PIPE_REGISTER_PARITY_EN stores even parity per stage.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_register #(
    parameter int               WIDTH       = 64,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pipe_register_if.slave     bus
);
    localparam int OCC_W = $clog2(STAGES + 1);

    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("pipe_register: STAGES must be at least 1");
        end
    endgenerate

    logic [STAGES-1:0][WIDTH-1:0] data;
    logic [STAGES-1:0]            vld;
    logic [OCC_W-1:0]             count;

    // Reset and flush share one clearing path; stall only blocks the shift.
    always_ff @(posedge clk) begin
        if (!reset || bus.flush) begin
            for (int i = 0; i < STAGES; i++) begin
                data[i] <= RESET_VALUE;
            end
            vld <= '0;
        end else if (!bus.stall) begin
            data[0] <= bus.D;
            vld[0]  <= bus.in_valid;
            for (int i = 1; i < STAGES; i++) begin
                data[i] <= data[i-1];
                vld[i]  <= vld[i-1];
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < STAGES; i++) begin
            count = count + OCC_W'(vld[i]);
        end
    end

    assign bus.Q         = data[STAGES-1];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.occupancy = count;

`ifdef PIPE_REGISTER_PARITY_EN
    logic [STAGES-1:0] par;

    always_ff @(posedge clk) begin
        if (!reset || bus.flush) begin
            par <= {STAGES{^RESET_VALUE}};
        end else if (!bus.stall) begin
            par[0] <= ^bus.D;
            for (int i = 1; i < STAGES; i++) begin
                par[i] <= par[i-1];
            end
        end
    end

    assign bus.parity_err = vld[STAGES-1] & ((^data[STAGES-1]) != par[STAGES-1]);
`endif
endmodule
`default_nettype wire

// File: tb/tb_pipe_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_register : randomized bench with history-based reference.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipe_register;
    localparam int              W   = 64;
    localparam int              S   = 3;
    localparam int              SW  = 8;
    localparam int              SS  = 1;
    localparam logic [SW-1:0]   SRV = 8'hA5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_register_if #(.WIDTH(W),  .STAGES(S))  bus_a ();
    pipe_register_if #(.WIDTH(SW), .STAGES(SS)) bus_b ();

    pipe_register #(.WIDTH(W), .STAGES(S), .RESET_VALUE('0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );
    pipe_register #(.WIDTH(SW), .STAGES(SS), .RESET_VALUE(SRV)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit known       = 0;
    bit inject      = 0;
    bit b_manual    = 0;

    // Reference: history of words accepted since the last clear; the last
    // stage holds the word accepted exactly STAGES accepting edges ago.
    typedef struct packed { logic v; logic [W-1:0] d;  } ent_a_t;
    typedef struct packed { logic v; logic [SW-1:0] d; } ent_b_t;
    ent_a_t hist_a[$];
    ent_b_t hist_b[$];

    always @(posedge clk) begin
        if (!reset) begin
            known = 1;
            hist_a.delete();
            hist_b.delete();
        end else begin
            if (bus_a.flush) hist_a.delete();
            else if (!bus_a.stall) begin
                hist_a.push_back({bus_a.in_valid, bus_a.D});
                if (hist_a.size() > S) void'(hist_a.pop_front());
            end
            if (bus_b.flush) hist_b.delete();
            else if (!bus_b.stall) begin
                hist_b.push_back({bus_b.in_valid, bus_b.D});
                if (hist_b.size() > SS) void'(hist_b.pop_front());
            end
        end
    end

    function automatic logic [W-1:0] exp_q_a();
        return (hist_a.size() == S) ? hist_a[0].d : '0;
    endfunction
    function automatic logic exp_v_a();
        return (hist_a.size() == S) ? hist_a[0].v : 1'b0;
    endfunction
    function automatic int exp_occ_a();
        int n = 0;
        foreach (hist_a[i]) n += int'(hist_a[i].v);
        return n;
    endfunction
    function automatic logic [SW-1:0] exp_q_b();
        return (hist_b.size() == SS) ? hist_b[0].d : SRV;
    endfunction
    function automatic logic exp_v_b();
        return (hist_b.size() == SS) ? hist_b[0].v : 1'b0;
    endfunction
    function automatic int exp_occ_b();
        int n = 0;
        foreach (hist_b[i]) n += int'(hist_b[i].v);
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (known && !inject) begin
            check("a_q",   bus_a.Q,                exp_q_a());
            check("a_ov",  64'(bus_a.out_valid),   64'(exp_v_a()));
            check("a_occ", 64'(bus_a.occupancy),   64'(exp_occ_a()));
            check("b_q",   64'(bus_b.Q),           64'(exp_q_b()));
            check("b_ov",  64'(bus_b.out_valid),   64'(exp_v_b()));
            check("b_occ", 64'(bus_b.occupancy),   64'(exp_occ_b()));
`ifdef PIPE_REGISTER_PARITY_EN
            check("a_perr", 64'(bus_a.parity_err), 64'd0);
            check("b_perr", 64'(bus_b.parity_err), 64'd0);
`endif
        end
    end

    task automatic rand_b();
        if (!b_manual) begin
            bus_b.stall    = ($urandom % 5) == 0;
            bus_b.flush    = ($urandom % 20) == 0;
            bus_b.in_valid = ($urandom % 4) != 0;
            bus_b.D        = SW'($urandom);
        end
    endtask

    task automatic step();
        rand_b();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic st, input logic fl, input logic iv, input logic [W-1:0] d);
        bus_a.stall = st; bus_a.flush = fl; bus_a.in_valid = iv; bus_a.D = d;
    endtask

    task automatic expect_a(input string name, input logic ov, input int occ, input logic [W-1:0] q, input bit chk_q);
        check({name, "_ov"},  64'(bus_a.out_valid), 64'(ov));
        check({name, "_occ"}, 64'(bus_a.occupancy), 64'(occ));
        if (chk_q) check({name, "_q"}, bus_a.Q, q);
    endtask

`ifdef PIPE_REGISTER_PARITY_EN
    logic [S-1:0][W-1:0]   flip_a;
    logic [SS-1:0][SW-1:0] flip_b;
`endif

    initial begin
        // 1: reset edge ignores D
        reset = 1'b0;
        drive_a(1'b0, 1'b0, 1'b1, 64'd77);
        step();
        expect_a("t1", 1'b0, 0, 64'd0, 1'b1);

        // 2: single word latency
        reset = 1'b1;
        drive_a(1'b0, 1'b0, 1'b1, 64'd527);
        step();
        expect_a("t2e1", 1'b0, 1, 64'd0, 1'b0);
        drive_a(1'b0, 1'b0, 1'b0, {$urandom, $urandom});
        step();
        expect_a("t2e2", 1'b0, 1, 64'd0, 1'b0);
        step();
        expect_a("t2e3", 1'b1, 1, 64'd527, 1'b1);
        step();
        expect_a("t2e4", 1'b0, 0, 64'd0, 1'b0);

        // 3: stream with a two-edge stall after the second word
        drive_a(1'b0, 1'b0, 1'b1, 64'd1); step();
        drive_a(1'b0, 1'b0, 1'b1, 64'd2); step();
        expect_a("t3pre", 1'b0, 2, 64'd0, 1'b0);
        drive_a(1'b1, 1'b0, 1'b1, 64'd3); step();
        expect_a("t3st1", 1'b0, 2, 64'd0, 1'b0);
        step();
        expect_a("t3st2", 1'b0, 2, 64'd0, 1'b0);
        drive_a(1'b0, 1'b0, 1'b1, 64'd3); step();
        expect_a("t3w1", 1'b1, 3, 64'd1, 1'b1);
        drive_a(1'b0, 1'b0, 1'b1, 64'd4); step();
        expect_a("t3w2", 1'b1, 3, 64'd2, 1'b1);
        drive_a(1'b0, 1'b0, 1'b0, 64'd0); step();
        expect_a("t3w3", 1'b1, 2, 64'd3, 1'b1);
        step();
        expect_a("t3w4", 1'b1, 1, 64'd4, 1'b1);
        step();
        expect_a("t3end", 1'b0, 0, 64'd0, 1'b0);

        // 4: flush beats stall and drops the incoming word
        drive_a(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8); step();
        drive_a(1'b0, 1'b0, 1'b1, 64'h3456_789A_BCDE_F012); step();
        drive_a(1'b0, 1'b0, 1'b1, 64'd981); step();
        expect_a("t4full", 1'b1, 3, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
        drive_a(1'b1, 1'b1, 1'b1, 64'd345); step();
        expect_a("t4fl", 1'b0, 0, 64'd0, 1'b1);
        drive_a(1'b0, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_a("t4post", 1'b0, 0, 64'd0, 1'b0);
        end

        // 5: reset wins over stall mid-stream
        drive_a(1'b0, 1'b0, 1'b1, 64'd11); step();
        drive_a(1'b0, 1'b0, 1'b1, 64'd12); step();
        expect_a("t5pre", 1'b0, 2, 64'd0, 1'b0);
        reset = 1'b0;
        drive_a(1'b1, 1'b0, 1'b1, 64'd99); step();
        expect_a("t5rst", 1'b0, 0, 64'd0, 1'b1);
        reset = 1'b1;
        drive_a(1'b0, 1'b0, 1'b1, 64'd18); step();
        drive_a(1'b0, 1'b0, 1'b0, 64'd0);
        expect_a("t5e1", 1'b0, 1, 64'd0, 1'b0);
        step();
        expect_a("t5e2", 1'b0, 1, 64'd0, 1'b0);
        step();
        expect_a("t5e3", 1'b1, 1, 64'd18, 1'b1);

        // Randomized traffic, checked every cycle against the history model
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom % 50) != 0;
            drive_a(($urandom % 5) == 0, ($urandom % 25) == 0, ($urandom % 10) < 7,
                    {$urandom, $urandom});
            step();
        end
        reset = 1'b1;

`ifdef PIPE_REGISTER_PARITY_EN
        // 6: corrupt the last stage and expect a one-cycle parity error
        b_manual = 1;
        bus_b.stall = 1'b0; bus_b.flush = 1'b0; bus_b.in_valid = 1'b1; bus_b.D = 8'h12;
        drive_a(1'b0, 1'b0, 1'b1, 64'h3456_789A_BCDE_F012);
        for (int i = 0; i < 4; i++) step();
        expect_a("t6pre", 1'b1, 3, 64'h3456_789A_BCDE_F012, 1'b1);
        check("t6_b_ov", 64'(bus_b.out_valid), 64'd1);
        inject = 1;
        flip_a = dut_a.data;
        flip_a[S-1][0] = ~flip_a[S-1][0];
        flip_b = dut_b.data;
        flip_b[SS-1][0] = ~flip_b[SS-1][0];
        force dut_a.data = flip_a;
        force dut_b.data = flip_b;
        #1;
        check("t6_a_perr_on", 64'(bus_a.parity_err), 64'd1);
        check("t6_b_perr_on", 64'(bus_b.parity_err), 64'd1);
        @(negedge clk);
        #1;
        release dut_a.data;
        release dut_b.data;
        step();
        inject = 0;
        check("t6_a_perr_off", 64'(bus_a.parity_err), 64'd0);
        check("t6_b_perr_off", 64'(bus_b.parity_err), 64'd0);
        step();
        b_manual = 0;
`endif

        drive_a(1'b0, 1'b0, 1'b0, 64'd0);
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
